// File: rtl/ram_bridge_tx_if.sv
// Command/memory/transmit signal bundle for the UART read-back responder.
interface ram_bridge_tx_if;
  logic [7:0]  data_in;
  logic        valid_in;
  logic [31:0] mem_addr_out;
  logic        mem_rd_en_out;
  logic [31:0] mem_data_in;
  logic [7:0]  tx_data_out;
  logic        tx_valid_out;
  logic        tx_ready_in;
  logic        busy_out;

  modport slave (
    input  data_in, valid_in, mem_data_in, tx_ready_in,
    output mem_addr_out, mem_rd_en_out, tx_data_out, tx_valid_out, busy_out
  );

  modport master (
    output data_in, valid_in, mem_data_in, tx_ready_in,
    input  mem_addr_out, mem_rd_en_out, tx_data_out, tx_valid_out, busy_out
  );
endinterface

// File: rtl/ram_bridge_tx.sv
// Parses 'R' + 4-byte LSB-first address, reads one word, streams it back LSB first.
// First tx byte READ_LATENCY+1 cycles after the read strobe; tx_valid_out holds byte until tx_ready_in.
module ram_bridge_tx #(
  parameter int READ_LATENCY   = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic            clk_in,
  input  logic            rst_in,
  ram_bridge_tx_if.slave  bus
);

  localparam logic [1:0]  IDLE = 2'd0;
  localparam logic [1:0]  ADDR = 2'd1;
  localparam logic [1:0]  READ = 2'd2;
  localparam logic [1:0]  SEND = 2'd3;
  localparam logic [7:0]  CMD_R    = 8'h52;
  localparam logic [2:0]  LAT_LAST = 3'(READ_LATENCY);
  localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST  = TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  logic [1:0]  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] addr_q, addr_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        rd_en_q, rd_en_d;
  logic [2:0]  lat_q, lat_d;
  logic [31:0] data_q, data_d;
  logic        tx_vld_q, tx_vld_d;
  logic [31:0] to_q, to_d;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    mem_addr_d = mem_addr_q;
    rd_en_d    = 1'b0;
    lat_d      = lat_q;
    data_d     = data_q;
    tx_vld_d   = tx_vld_q;
    to_d       = to_q;

    case (state_q)
      IDLE: begin
        if (bus.valid_in && bus.data_in == CMD_R) begin
          state_d = ADDR;
          idx_d   = 2'd0;
          to_d    = 32'd0;
        end
      end
      ADDR: begin
        if (bus.valid_in) begin
          to_d = 32'd0;
          if (idx_q == 2'd3) begin
            // The top byte goes straight to the port so the address and strobe align.
            mem_addr_d = {bus.data_in, addr_q};
            state_d    = READ;
            rd_en_d    = 1'b1;
            lat_d      = 3'd0;
          end else begin
            addr_d[{idx_q, 3'b000} +: 8] = bus.data_in;
            idx_d = idx_q + 2'd1;
          end
        end else if (TO_EN) begin
          if (to_q == TO_LAST) begin
            state_d = IDLE;
          end else begin
            to_d = to_q + 32'd1;
          end
        end
      end
      READ: begin
        if (lat_q == LAT_LAST) begin
          data_d   = bus.mem_data_in;
          state_d  = SEND;
          idx_d    = 2'd0;
          tx_vld_d = 1'b1;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      SEND: begin
        if (tx_vld_q && bus.tx_ready_in) begin
          if (idx_q == 2'd3) begin
            tx_vld_d = 1'b0;
            state_d  = IDLE;
            idx_d    = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      addr_q     <= 24'd0;
      mem_addr_q <= 32'd0;
      rd_en_q    <= 1'b0;
      lat_q      <= 3'd0;
      data_q     <= 32'd0;
      tx_vld_q   <= 1'b0;
      to_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      mem_addr_q <= mem_addr_d;
      rd_en_q    <= rd_en_d;
      lat_q      <= lat_d;
      data_q     <= data_d;
      tx_vld_q   <= tx_vld_d;
      to_q       <= to_d;
    end
  end

  assign bus.mem_addr_out  = mem_addr_q;
  assign bus.mem_rd_en_out = rd_en_q;
  assign bus.tx_valid_out  = tx_vld_q;
  assign bus.tx_data_out   = tx_vld_q ? data_q[{idx_q, 3'b000} +: 8] : 8'h00;
  assign bus.busy_out      = (state_q != IDLE);

endmodule

// File: tb/tb_ram_bridge_tx.sv
// Bench for ram_bridge_tx: vector table, corner sequences and random commands vs. a word-level model.
module tb_ram_bridge_tx;
  localparam int LAT = 2;
  localparam int TO  = 50;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int unsigned cyc = 0;
  int errors = 0;
  int checks = 0;

  ram_bridge_tx_if bus();

  ram_bridge_tx #(.READ_LATENCY(LAT), .TIMEOUT_CYCLES(TO)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Memory: data is only meaningful in the cycle exactly LAT after the strobe.
  logic        pv [1:LAT];
  logic [31:0] pa [1:LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= LAT; k++) begin
        pv[k] <= 1'b0;
        pa[k] <= 32'd0;
      end
    end else begin
      pv[1] <= bus.mem_rd_en_out;
      pa[1] <= bus.mem_addr_out;
      for (int k = 2; k <= LAT; k++) begin
        pv[k] <= pv[k-1];
        pa[k] <= pa[k-1];
      end
    end
  end
  assign bus.mem_data_in = pv[LAT] ? word_of(pa[LAT]) : (32'hBAD00000 | {16'h0, cyc[15:0]});

  // 0: always ready, 1: never, 2: every 5th cycle, 3: random
  int rdy_mode = 0;
  initial begin
    bus.tx_ready_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.tx_ready_in = 1'b1;
        1:       bus.tx_ready_in = 1'b0;
        2:       bus.tx_ready_in = (cyc % 5 == 0);
        default: bus.tx_ready_in = 1'($urandom_range(0, 1));
      endcase
    end
  end

  logic [31:0] rd_addr_q [$];
  int unsigned rd_cyc_q  [$];
  int unsigned vld_cyc_q [$];
  logic [7:0]  tx_dat_q  [$];
  int unsigned tx_cyc_q  [$];
  logic        p_vld = 1'b0;
  logic        p_rdy = 1'b0;
  logic [7:0]  p_dat = 8'h00;
  int          word_cnt = 0;
  bit          busy_seen = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_vld = 1'b0;
        p_rdy = 1'b0;
        word_cnt = 0;
      end else begin
        if (bus.busy_out) busy_seen = 1'b1;
        if (bus.mem_rd_en_out) begin
          rd_addr_q.push_back(bus.mem_addr_out);
          rd_cyc_q.push_back(cyc);
        end
        if (p_vld && !p_rdy) begin
          chk("stall_valid_held", 32'(bus.tx_valid_out), 32'd1);
          chk("stall_data_held", 32'(bus.tx_data_out), 32'(p_dat));
        end else if (p_vld && p_rdy) begin
          chk("valid_after_transfer", 32'(bus.tx_valid_out), 32'(word_cnt != 0));
        end
        if (bus.tx_valid_out && !p_vld) vld_cyc_q.push_back(cyc);
        if (bus.tx_valid_out && bus.tx_ready_in) begin
          tx_dat_q.push_back(bus.tx_data_out);
          tx_cyc_q.push_back(cyc);
          word_cnt = (word_cnt + 1) % 4;
        end
        p_vld = bus.tx_valid_out;
        p_rdy = bus.tx_ready_in;
        p_dat = bus.tx_data_out;
      end
    end
  end

  task automatic clear_mon();
    rd_addr_q.delete();
    rd_cyc_q.delete();
    vld_cyc_q.delete();
    tx_dat_q.delete();
    tx_cyc_q.delete();
    busy_seen = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.data_in  = b;
    bus.valid_in = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    bus.data_in  = 8'($urandom);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 3000; i++) begin
      if (!bus.busy_out) break;
      @(posedge clk);
      #1;
    end
    chk({name, "_finished"}, 32'(bus.busy_out), 32'd0);
    idle(8);
  endtask

  task automatic check_cmd(input string name, input int reads, input logic [31:0] addr, input bit lat_exact);
    logic [31:0] w;
    w = word_of(addr);
    chk({name, "_reads"}, 32'(rd_addr_q.size()), 32'(reads));
    if (reads == 0) begin
      chk({name, "_tx_count"}, 32'(tx_dat_q.size()), 32'd0);
    end else if (rd_addr_q.size() == 1) begin
      chk({name, "_addr"}, rd_addr_q[0], addr);
      chk({name, "_tx_count"}, 32'(tx_dat_q.size()), 32'd4);
      for (int k = 0; k < 4 && k < tx_dat_q.size(); k++)
        chk($sformatf("%s_byte%0d", name, k), 32'(tx_dat_q[k]), (w >> (8 * k)) & 32'hFF);
      chk({name, "_valid_starts"}, 32'(vld_cyc_q.size()), 32'd1);
      if (vld_cyc_q.size() >= 1)
        chk({name, "_first_valid_cycle"}, vld_cyc_q[0], rd_cyc_q[0] + LAT + 1);
      if (lat_exact)
        for (int k = 0; k < tx_cyc_q.size(); k++)
          chk($sformatf("%s_xfer_cycle%0d", name, k), tx_cyc_q[k], rd_cyc_q[0] + LAT + 1 + k);
    end
  endtask

  typedef struct packed {
    logic [79:0] bytes;  // first byte sent in [7:0]
    logic [3:0]  n;
    logic        rd;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl [5];

  initial begin
    logic [31:0] a;
    logic [7:0]  b;
    bus.data_in  = 8'h00;
    bus.valid_in = 1'b0;

    tbl[0] = '{80'h00_00_00_10_52, 4'd5, 1'b1, 32'h00000010};
    tbl[1] = '{80'h41_44_33_22_11_00_00_00_00_57, 4'd10, 1'b0, 32'h0};
    tbl[2] = '{80'h00_00_00_04_52, 4'd5, 1'b1, 32'h00000004};
    tbl[3] = '{80'h52_52_52_52_52, 4'd5, 1'b1, 32'h52525252};
    tbl[4] = '{80'h12_34_56_78_52, 4'd5, 1'b1, 32'h12345678};

    #2 rst_n = 1'b0;
    #6;
    chk("reset_mem_addr", bus.mem_addr_out, 32'd0);
    chk("reset_rd_en", 32'(bus.mem_rd_en_out), 32'd0);
    chk("reset_tx_data", 32'(bus.tx_data_out), 32'd0);
    chk("reset_tx_valid", 32'(bus.tx_valid_out), 32'd0);
    chk("reset_busy", 32'(bus.busy_out), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    rdy_mode = 0;
    for (int i = 0; i < 5; i++) begin
      clear_mon();
      for (int k = 0; k < int'(tbl[i].n); k++) send_byte(tbl[i].bytes[8*k +: 8]);
      wait_done($sformatf("vec%0d", i));
      check_cmd($sformatf("vec%0d", i), int'(tbl[i].rd), tbl[i].addr, 1'b1);
      if (!tbl[i].rd) chk($sformatf("vec%0d_busy_seen", i), 32'(busy_seen), 32'd0);
    end

    // Backpressure
    rdy_mode = 2;
    clear_mon();
    send_byte(8'h52); send_byte(8'h10); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    wait_done("bp");
    check_cmd("bp", 1, 32'h10, 1'b0);
    rdy_mode = 0;

    // Timeout boundary: 49 idle cycles survive, the 50th abandons the command
    clear_mon();
    send_byte(8'h52); send_byte(8'h08);
    idle(TO - 1);
    chk("to_busy_before_limit", 32'(bus.busy_out), 32'd1);
    idle(1);
    chk("to_busy_after_limit", 32'(bus.busy_out), 32'd0);
    chk("to_addr_unchanged", bus.mem_addr_out, 32'h10);
    send_byte(8'h52); idle(TO - 1);
    send_byte(8'h0C); idle(TO - 1);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    wait_done("to");
    check_cmd("to", 1, 32'h0C, 1'b1);

    // Bytes injected while the response is stalled are ignored
    rdy_mode = 1;
    clear_mon();
    send_byte(8'h52); send_byte(8'h30); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    for (int i = 0; i < 50; i++) begin
      if (bus.tx_valid_out) break;
      idle(1);
    end
    chk("inj_valid_stalled", 32'(bus.tx_valid_out), 32'd1);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    idle(3);
    rdy_mode = 0;
    wait_done("inj");
    idle(20);
    check_cmd("inj", 1, 32'h30, 1'b0);

    // Asynchronous reset after two bytes have gone out
    clear_mon();
    send_byte(8'h52); send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
    for (int i = 0; i < 100; i++) begin
      if (tx_dat_q.size() >= 2) break;
      idle(1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_tx_valid", 32'(bus.tx_valid_out), 32'd0);
    chk("rst_mid_busy", 32'(bus.busy_out), 32'd0);
    chk("rst_mid_tx_sent", 32'(tx_dat_q.size()), 32'd2);
    idle(3);
    rst_n = 1'b1;
    idle(20);
    chk("rst_after_tx_sent", 32'(tx_dat_q.size()), 32'd2);
    chk("rst_after_reads", 32'(rd_addr_q.size()), 32'd1);
    clear_mon();
    send_byte(8'h52); send_byte(8'h10); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    wait_done("rst_new");
    check_cmd("rst_new", 1, 32'h10, 1'b1);

    // Random commands with garbage, gaps, backpressure and injected bytes
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 2))
        0:       rdy_mode = 0;
        1:       rdy_mode = 2;
        default: rdy_mode = 3;
      endcase
      clear_mon();
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom);
        if (b == 8'h52) b = 8'h53;
        send_byte(b);
        idle($urandom_range(0, 3));
      end
      a = $urandom;
      send_byte(8'h52);
      for (int k = 0; k < 4; k++) begin
        idle($urandom_range(0, 5));
        send_byte(a[8*k +: 8]);
      end
      if ($urandom_range(0, 1) == 1) send_byte(8'h52);
      wait_done($sformatf("rnd%0d", it));
      check_cmd($sformatf("rnd%0d", it), 1, a, rdy_mode == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
